// File: rtl/pc_target_table_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_target_pkg                                                              |
// | Shared types, default sizes and the reset-time jump map for the table.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pc_target_pkg;

  localparam int DEF_D     = 12;
  localparam int DEF_DEPTH = 32;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } fsm_e;

  function automatic logic [DEF_D-1:0] default_target(input int unsigned idx);
    logic [DEF_D-1:0] t;
    t = '0;
    case (idx)
      0:  t = 12'd6;
      1:  t = 12'd6;
      2:  t = 12'd503;
      3:  t = 12'd328;
      4:  t = 12'd298;
      5:  t = 12'd315;
      6:  t = 12'd282;
      7:  t = 12'd266;
      8:  t = 12'd247;
      9:  t = 12'd231;
      10: t = 12'd215;
      11: t = 12'd199;
      12: t = 12'd177;
      13: t = 12'd161;
      14: t = 12'd145;
      16: t = 12'd35;
      17: t = 12'd65;
      18: t = 12'd101;
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_target_table_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_target_table_if                                                         |
// | Lookup/write bus between the decoder side and the target table.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface pc_target_table_if
  import pc_target_pkg::*;
#(
  parameter int D  = DEF_D,
  parameter int AW = 8
);

  logic          ready;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic          rd_hit;
  logic [D-1:0]  rd_target;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [D-1:0]  wr_data;
  logic          wr_rej;

  modport master (
    output rd_req, rd_addr, wr_en, wr_addr, wr_data,
    input  ready, rd_valid, rd_hit, rd_target, wr_rej
  );

  modport slave (
    input  rd_req, rd_addr, wr_en, wr_addr, wr_data,
    output ready, rd_valid, rd_hit, rd_target, wr_rej
  );

endinterface
`default_nettype wire

// File: rtl/pc_target_table_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_target_ram                                                              |
// | DEPTH x D register array, one synchronous write port, one registered read. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pc_target_ram #(
  parameter int D     = 12,
  parameter int DEPTH = 32,
  parameter int RAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           we_i,
  input  logic [RAW-1:0] waddr_i,
  input  logic [D-1:0]   wdata_i,
  input  logic           re_i,
  input  logic [RAW-1:0] raddr_i,
  input  logic           ovr_i,
  input  logic [D-1:0]   ovr_data_i,
  output logic [D-1:0]   rdata_o
);

  logic [D-1:0] mem_q [DEPTH];
  logic [D-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The override path lets the caller substitute a miss value or forwarded data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= ovr_i ? ovr_data_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/pc_target_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_target_table                                                            |
// | Programmable branch/jump target table, init walker loads the default map.  |
// | Optional: PC_TARGET_BYPASS_EN enables write-first forwarding.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pc_target_table
  import pc_target_pkg::*;
#(
  parameter int D     = DEF_D,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  pc_target_table_if.slave     bus
);

  localparam int            RAW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  fsm_e           state_q;
  logic [RAW-1:0] cnt_q;

  logic           in_init;
  logic           rd_in;
  logic           wr_in;
  logic           wr_ok;
  logic           rd_go;
  logic           byp;

  logic           ram_we;
  logic [RAW-1:0] ram_waddr;
  logic [D-1:0]   ram_wdata;
  logic           ram_ovr;
  logic [D-1:0]   ram_ovr_data;

  logic           rd_valid_d, rd_valid_q;
  logic           rd_hit_d,   rd_hit_q;
  logic           wr_rej_d,   wr_rej_q;

  assign in_init = (state_q == INIT);
  assign rd_in   = (bus.rd_addr < DEPTH_A);
  assign wr_in   = (bus.wr_addr < DEPTH_A);
  assign wr_ok   = !in_init && bus.wr_en && wr_in;
  assign rd_go   = !in_init && bus.rd_req;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == RAW'(DEPTH - 1)) begin
            state_q <= READY;
          end
        end
        READY:   state_q <= READY;
        default: state_q <= INIT;
      endcase
    end
  end

  // The init walker owns the write port until the table is ready.
  assign ram_we    = in_init || wr_ok;
  assign ram_waddr = in_init ? cnt_q : bus.wr_addr[RAW-1:0];
  assign ram_wdata = in_init ? D'(default_target(32'(cnt_q))) : bus.wr_data;

`ifdef PC_TARGET_BYPASS_EN
  assign byp = wr_ok && rd_in && (bus.wr_addr == bus.rd_addr);
`else
  assign byp = 1'b0;
`endif

  assign ram_ovr      = !rd_in || byp;
  assign ram_ovr_data = byp ? bus.wr_data : '0;

  always_comb begin
    rd_valid_d = rd_go;
    rd_hit_d   = rd_go && rd_in;
    wr_rej_d   = bus.wr_en && !wr_ok;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      wr_rej_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_hit_q   <= rd_hit_d;
      wr_rej_q   <= wr_rej_d;
    end
  end

  pc_target_ram #(
    .D     (D),
    .DEPTH (DEPTH),
    .RAW   (RAW)
  ) u_ram (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .we_i       (ram_we),
    .waddr_i    (ram_waddr),
    .wdata_i    (ram_wdata),
    .re_i       (rd_go),
    .raddr_i    (bus.rd_addr[RAW-1:0]),
    .ovr_i      (ram_ovr),
    .ovr_data_i (ram_ovr_data),
    .rdata_o    (bus.rd_target)
  );

  assign bus.ready    = (state_q == READY);
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_hit   = rd_hit_q;
  assign bus.wr_rej   = wr_rej_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_target_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc_target_table                                                         |
// | Directed stimulus with a queue-based lookup scoreboard for pc_target_table.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pc_target_table;
  import pc_target_pkg::*;

  localparam int D     = 12;
  localparam int DEPTH = 32;
  localparam int AW    = 8;

  typedef struct {
    int           due;
    logic         hit;
    logic [D-1:0] tgt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t me;

  pc_target_table_if #(.D(D), .AW(AW)) bus ();

  pc_target_table #(.D(D), .DEPTH(DEPTH), .AW(AW)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic h, input logic [D-1:0] t);
    exp_t e;
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    e.due = cyc + 1;
    e.hit = h;
    e.tgt = t;
    sb.push_back(e);
    tick();
    bus.rd_req = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [D-1:0] d, input logic rej);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    chk("wr_rej", 32'(bus.wr_rej), 32'(rej));
  endtask

  task automatic flush();
    repeat (3) tick();
  endtask

  // Reads held and a write issued during the walk must be ignored / rejected.
  task automatic init_walk(input string nm);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 8'd2;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 8'd1;
    bus.wr_data = 12'd7;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      if (i == 1) begin
        chk({nm, "_wr_rej_init"}, 32'(bus.wr_rej), 32'd1);
        bus.wr_en = 1'b0;
      end else if (i == 2) begin
        chk({nm, "_wr_rej_pulse"}, 32'(bus.wr_rej), 32'd0);
      end
      chk({nm, "_ready"}, 32'(bus.ready), (i == DEPTH) ? 32'd1 : 32'd0);
    end
    bus.rd_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      tests++;
      fails++;
      $display("FAIL rd_missing: rd_valid=0 at cycle %0d, required 1 at cycle %0d", cyc, sb[0].due);
      sb.delete(0);
    end
    if (!rst && bus.rd_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: rd_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        me = sb.pop_front();
        if (me.due != cyc || bus.rd_hit !== me.hit || bus.rd_target !== me.tgt) begin
          fails++;
          $display("FAIL rd_lookup: cycle %0d hit %0b target %0h, required cycle %0d hit %0b target %0h",
                   cyc, bus.rd_hit, bus.rd_target, me.due, me.hit, me.tgt);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ready",     32'(bus.ready),     32'd0);
    chk("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
    chk("rst_rd_hit",    32'(bus.rd_hit),    32'd0);
    chk("rst_wr_rej",    32'(bus.wr_rej),    32'd0);
    chk("rst_rd_target", 32'(bus.rd_target), 32'd0);
    rst = 1'b0;

    init_walk("init1");
    rd(8'd2, 1'b1, 12'd503);
    flush();

    rd(8'd3, 1'b1, 12'd328);
    rd(8'd4, 1'b1, 12'd298);
    rd(8'd5, 1'b1, 12'd315);
    flush();
    chk("hold_rd_valid",  32'(bus.rd_valid),  32'd0);
    chk("hold_rd_target", 32'(bus.rd_target), 32'd315);

    rd(8'd0,   1'b1, 12'd6);
    rd(8'd14,  1'b1, 12'd145);
    rd(8'd31,  1'b1, 12'd0);
    rd(8'd32,  1'b0, 12'd0);
    rd(8'd255, 1'b0, 12'd0);
    flush();

    wr(8'd15, 12'h123, 1'b0);
    rd(8'd15, 1'b1, 12'h123);
    wr(8'd40, 12'h055, 1'b1);
    tick();
    chk("wr_rej_pulse", 32'(bus.wr_rej), 32'd0);
    rd(8'd40, 1'b0, 12'd0);
    wr(8'd32, 12'h001, 1'b1);
    rd(8'd0, 1'b1, 12'd6);
    flush();

    bus.wr_en   = 1'b1;
    bus.wr_addr = 8'd3;
    bus.wr_data = 12'h0AA;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 8'd3;
    e.due = cyc + 1;
    e.hit = 1'b1;
`ifdef PC_TARGET_BYPASS_EN
    e.tgt = 12'h0AA;
`else
    e.tgt = 12'd328;
`endif
    sb.push_back(e);
    tick();
    bus.wr_en  = 1'b0;
    bus.rd_req = 1'b0;
    chk("same_edge_wr_rej", 32'(bus.wr_rej), 32'd0);
    rd(8'd3, 1'b1, 12'h0AA);
    flush();

    wr(8'd15, 12'h123, 1'b0);
    flush();
    rst = 1'b1;
    #1;
    chk("async_ready",     32'(bus.ready),     32'd0);
    chk("async_rd_target", 32'(bus.rd_target), 32'd0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    init_walk("init2");
    rd(8'd1,  1'b1, 12'd6);
    rd(8'd15, 1'b1, 12'd0);
    rd(8'd16, 1'b1, 12'd35);
    rd(8'd3,  1'b1, 12'd328);
    flush();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
